led_matrix_scan: RTL and testbench
==================================

// Module: led_matrix_scan
// PURPOSE
//  Parametrised row-scanned LED matrix driver with per-pixel PWM brightness and a double-buffered framebuffer.
//  Successor to the fixed 8x8 on/off matrix driver. Sits between the user logic (pixel writes, buffer swaps)
//  and the board's row/column drive pins. Adds blanking between rows to stop ghosting.
// PARAMETERS
//  ROWS        8  number of matrix rows (scanned one at a time)
//  COLS        8  number of matrix columns (driven in parallel)
//  BPP         4  brightness bits per pixel; 2^BPP levels, 0 = off
//  PRESCALE    4  clk cycles per PWM step (>=1)
//  BLANK       2  clk cycles all-off before each row (>=1)
//  ROW_ACT_HI  1  1: active row pin driven high; 0: driven low
//  COL_ACT_HI  1  1: lit column pin driven high; 0: driven low
// PORTS
//  clk          in   1                      system clock
//  rst_n        in   1                      asynchronous, active-low reset
//  enable       in   1                      1 = scan; 0 = all LEDs off, scan held
//  wr_en        in   1                      pixel write strobe
//  wr_addr      in   $clog2(ROWS*COLS)      pixel index = row*COLS + col
//  wr_data      in   BPP                    pixel brightness
//  swap_req     in   1                      pulse: swap front/back buffers at the next frame boundary
//  swap_pend    out  1                      swap requested, not yet applied
//  swap_done    out  1                      1-cycle pulse when the swap takes effect
//  frame_start  out  1                      1-cycle pulse when row 0 blanking begins
//  row_out      out  ROWS                   row drive, one-hot active when lit
//  col_out      out  COLS                   column drive
// BEHAVIOUR
//  Reset: both buffers cleared to 0, front=0, row=0, state IDLE. row_out/col_out at inactive level.
//    frame_start, swap_done and swap_pend are 0.
//  FSM states: IDLE, BLANK, PWM.
//   IDLE: row_out and col_out inactive. enable=1 -> BLANK with row=0.
//   BLANK: lasts BLANK cycles, all outputs inactive. Then go to PWM with step=0.
//   PWM: lasts (2^BPP-1) steps of PRESCALE cycles each.
//    - row_out[row] active for the whole phase.
//    - col_out[c] active iff front[row*COLS+c] > step.
//    - Level 0 is never lit. Level 2^BPP-1 is lit for the whole PWM phase.
//    - End of phase: row++ and go to BLANK. Row wraps ROWS-1 -> 0.
//  Row period = BLANK + (2^BPP-1)*PRESCALE clocks. Frame period = ROWS * row period.
//  Outputs are registered and reflect the current state/counters one cycle after they change.
//  frame_start pulses in the first cycle of BLANK for row 0, including the first entry from IDLE.
//  enable=0 in any state: next cycle IDLE, outputs inactive, counters cleared. Buffers and swap_pend are kept.
//  Writes:
//   - wr_en writes wr_data into the back buffer at wr_addr, effective next cycle.
//   - wr_addr >= ROWS*COLS is ignored.
//  Swap:
//   - swap_req sets swap_pend.
//   - The swap happens on the edge where the row wraps ROWS-1 -> 0, or on the IDLE -> BLANK edge.
//   - On that edge front toggles, swap_pend clears, and swap_done pulses for one cycle.
//  Simultaneous swap_req on the swap edge: the swap executes and swap_pend stays 1 for the next frame.
//  Simultaneous wr_en on the swap edge: the write lands in the pre-swap back buffer, which becomes front.
//  The displayed buffer never changes mid-frame.
//  Reset asserted mid-frame: outputs inactive asynchronously, all state returns to reset values.
// TESTING (defaults, PRESCALE=4, BLANK=2: row period 62, frame 496 clocks)
//  1. Reset, enable=1, no writes, one swap -> col_out all inactive for a full frame.
//     frame_start every 496 clocks.
//  2. Write addr 0 = 15, addr 1 = 8, addr 2 = 0, swap -> row 0:
//     col0 lit 60 clocks, col1 lit 32 clocks, col2 never lit.
//  3. Scan a full frame -> row_out one-hot, order 0..7, each active 60 clocks.
//     2 all-off blank clocks precede every row.
//  4. swap_req mid-frame -> swap_pend=1 until the wrap.
//     swap_done pulses exactly once, aligned with frame_start. No visible change before it.
//  5. wr_en with addr 64 -> no buffer change.
//     wr_en on the swap edge -> the new pixel is shown in the frame that starts.
//  6. Drop enable mid-PWM -> outputs inactive next cycle.
//     Re-enable -> frame_start, row 0 starts. Assert rst_n=0 mid-frame -> outputs inactive immediately.

Source files
------------

// File: rtl/led_matrix_scan_if.sv
// Pixel-write / buffer-swap port bundle for led_matrix_scan.
//   wr_en, wr_addr, wr_data : pixel write into the back buffer (index = row*COLS + col)
//   swap_req                : pulse, request a front/back swap at the next frame boundary
//   swap_pend, swap_done    : swap status back to the user logic
// master = user logic, slave = the matrix driver.
interface led_matrix_scan_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BPP  = 4
);
  localparam int AW = $clog2(ROWS*COLS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BPP-1:0] wr_data;
  logic          swap_req;
  logic          swap_pend;
  logic          swap_done;

  modport master (output wr_en, wr_addr, wr_data, swap_req, input swap_pend, swap_done);
  modport slave  (input wr_en, wr_addr, wr_data, swap_req, output swap_pend, swap_done);
endinterface

// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver with per-pixel PWM brightness and a
// double-buffered framebuffer. Each row gets BLANK all-off clocks followed by
// (2^BPP-1) PWM steps of PRESCALE clocks; a pixel is lit while level > step.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 1 = scan, 0 = everything off and scan parked in IDLE
//   bus          : pixel writes / swap handshake (led_matrix_scan_if.slave)
//   frame_start  : 1-cycle pulse as row 0 blanking begins
//   row_out      : one-hot row drive (polarity ROW_ACT_HI)
//   col_out      : column drive (polarity COL_ACT_HI)
module led_matrix_scan #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BPP        = 4,
  parameter int PRESCALE   = 4,
  parameter int BLANK      = 2,
  parameter bit ROW_ACT_HI = 1'b1,
  parameter bit COL_ACT_HI = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  led_matrix_scan_if.slave  bus,
  output logic              frame_start,
  output logic [ROWS-1:0]   row_out,
  output logic [COLS-1:0]   col_out
);
  localparam int NPIX  = ROWS*COLS;
  localparam int AW    = $clog2(NPIX);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int NSTEP = (1 << BPP) - 1;
  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{~ROW_ACT_HI}};
  localparam logic [COLS-1:0] COL_OFF = {COLS{~COL_ACT_HI}};

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_PWM} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [BPP-1:0] step_q, step_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [BW-1:0]  blk_q, blk_d;
  logic           frame_edge, do_swap;
  logic           front_q, swap_pend_q;
  logic [1:0][NPIX-1:0][BPP-1:0] fb;
  logic [COLS-1:0] lit;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    step_d     = step_q;
    pre_d      = pre_q;
    blk_d      = blk_q;
    frame_edge = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      row_d   = '0;
      step_d  = '0;
      pre_d   = '0;
      blk_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_BLANK;
          row_d      = '0;
          blk_d      = '0;
          frame_edge = 1'b1;
        end
        S_BLANK:
          if (blk_q == BW'(BLANK-1)) begin
            state_d = S_PWM;
            step_d  = '0;
            pre_d   = '0;
          end else blk_d = blk_q + 1'b1;
        S_PWM:
          if (pre_q == PW'(PRESCALE-1)) begin
            pre_d = '0;
            if (step_q == BPP'(NSTEP-1)) begin
              state_d = S_BLANK;
              blk_d   = '0;
              if (row_q == RW'(ROWS-1)) begin
                row_d      = '0;
                frame_edge = 1'b1;
              end else row_d = row_q + 1'b1;
            end else step_d = step_q + 1'b1;
          end else pre_d = pre_q + 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Swaps only land on a frame boundary so the displayed image never tears.
  assign do_swap       = frame_edge & swap_pend_q;
  assign bus.swap_pend = swap_pend_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [AW-1:0] pix;
    assign pix    = AW'(int'(row_q)*COLS + c);
    assign lit[c] = fb[front_q][pix] > step_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      step_q        <= '0;
      pre_q         <= '0;
      blk_q         <= '0;
      front_q       <= 1'b0;
      swap_pend_q   <= 1'b0;
      bus.swap_done <= 1'b0;
      frame_start   <= 1'b0;
      row_out       <= ROW_OFF;
      col_out       <= COL_OFF;
      fb            <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      // Uses the pre-swap back index, so a write on the swap edge becomes visible in the new frame.
      if (bus.wr_en && int'(bus.wr_addr) < NPIX)
        fb[~front_q][bus.wr_addr] <= bus.wr_data;
      if (do_swap) front_q <= ~front_q;
      // A request arriving on the swap edge re-arms for the following frame.
      swap_pend_q   <= bus.swap_req | (swap_pend_q & ~do_swap);
      bus.swap_done <= do_swap;
      frame_start   <= frame_edge;
      if (enable && state_q == S_PWM) begin
        row_out <= ROW_OFF ^ (ROWS'(1) << row_q);
        col_out <= COL_OFF ^ lit;
      end else begin
        row_out <= ROW_OFF;
        col_out <= COL_OFF;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: an arithmetic frame-timing model checked every
// cycle, directed scenarios with literal expectations, and a small
// active-low 3x3 instance for out-of-range write addresses.
module tb_led_matrix_scan;
  localparam int ROWS = 8, COLS = 8, BPP = 4, PRE = 4, BLK = 2;
  localparam int RP = BLK + ((1 << BPP) - 1)*PRE;  // 62
  localparam int FP = ROWS*RP;                     // 496

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic frame_start;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;
  logic enable2 = 1'b0, frame_start2;
  logic [2:0] row_out2, col_out2;

  led_matrix_scan_if #(.ROWS(8), .COLS(8), .BPP(4)) bus();
  led_matrix_scan_if #(.ROWS(3), .COLS(3), .BPP(2)) bus2();

  led_matrix_scan #(.ROWS(8), .COLS(8), .BPP(4), .PRESCALE(4), .BLANK(2),
                    .ROW_ACT_HI(1'b1), .COL_ACT_HI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .frame_start(frame_start), .row_out(row_out), .col_out(col_out));

  led_matrix_scan #(.ROWS(3), .COLS(3), .BPP(2), .PRESCALE(1), .BLANK(1),
                    .ROW_ACT_HI(1'b0), .COL_ACT_HI(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .bus(bus2),
    .frame_start(frame_start2), .row_out(row_out2), .col_out(col_out2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: position in frame from a cycle count ----------------
  int mk = 0;
  bit mrun = 0, mpend = 0;
  logic [3:0] mfront [64];
  logic [3:0] mback  [64];
  logic [7:0] erow = '0, ecol = '0;
  bit efs = 0, edone = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int p, r, q;
    bit did;
    logic [3:0] t;
    if (!rst_n) begin
      mrun = 0; mk = 0; mpend = 0;
      erow = '0; ecol = '0; efs = 0; edone = 0;
      for (int i = 0; i < 64; i++) begin mfront[i] = '0; mback[i] = '0; end
    end else begin
      did = 0; erow = '0; ecol = '0; efs = 0;
      if (enable) begin
        if (!mrun) begin mrun = 1; mk = 0; end else mk++;
        // outputs show the scan position of the previous cycle
        if (mk > 0) begin
          p = (mk - 1) % FP; r = p / RP; q = p % RP;
          if (q >= BLK) begin
            erow = 8'(1 << r);
            for (int c = 0; c < COLS; c++) ecol[c] = (mfront[r*COLS + c] > (q - BLK)/PRE);
          end
        end
        if (mk % FP == 0) begin efs = 1; did = mpend; end
      end else mrun = 0;
      if (bus.wr_en) mback[bus.wr_addr] = bus.wr_data;
      if (did)
        for (int i = 0; i < 64; i++) begin t = mfront[i]; mfront[i] = mback[i]; mback[i] = t; end
      edone = did;
      mpend = bus.swap_req | (mpend & !did);
    end
  end

  always @(negedge clk) begin
    chk("row_out", row_out, erow);
    chk("col_out", col_out, ecol);
    chk("frame_start", frame_start, efs);
    chk("swap_done", bus.swap_done, edone);
    chk("swap_pend", bus.swap_pend, mpend);
  end

  // ---------------- observation counters for literal checks ----------------
  int cyc = 0, fs_cnt, fs_gap, last_fs, done_cnt, blank_cnt, bad_oh, order_err, lastr, anycol;
  int row_cnt [8];
  int r0c [3];

  task automatic clr();
    fs_cnt = 0; fs_gap = 0; last_fs = -1; done_cnt = 0; blank_cnt = 0;
    bad_oh = 0; order_err = 0; lastr = -1; anycol = 0;
    for (int i = 0; i < 8; i++) row_cnt[i] = 0;
    for (int i = 0; i < 3; i++) r0c[i] = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_start) begin
        if (last_fs >= 0) fs_gap = cyc - last_fs;
        last_fs = cyc; fs_cnt++;
      end
      if (bus.swap_done) done_cnt++;
      if (col_out != 0) anycol++;
      if (row_out == 0) blank_cnt++;
      else if ($onehot(row_out)) begin
        for (int r = 0; r < 8; r++)
          if (row_out[r]) begin
            row_cnt[r]++;
            if (lastr >= 0 && r != lastr && r != (lastr + 1) % 8) order_err++;
            lastr = r;
          end
        if (row_out[0]) for (int c = 0; c < 3; c++) if (col_out[c]) r0c[c]++;
      end else bad_oh++;
    end
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = 6'(a); bus.wr_data = 4'(d);
    run(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic wr2(input int a, input int d);
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'(a); bus2.wr_data = 2'(d);
    run(1);
    bus2.wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1; run(1); bus.swap_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    do begin run(1); n++; end while (!bus.swap_done && n < lim);
    chk(nm, bus.swap_done, 1);
  endtask

  initial begin
    int lit2 [9];
    int row2act, others, n;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap_req = 0;
    bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.swap_req = 0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_row", row_out, 8'h00);
    chk("rst_col", col_out, 8'h00);
    chk("rst_fs", frame_start, 0);
    chk("rst_pend", bus.swap_pend, 0);
    chk("rst_done", bus.swap_done, 0);
    chk("rst_row2_lo", row_out2, 3'b111);
    chk("rst_col2_lo", col_out2, 3'b111);
    rst_n = 1'b1;
    run(2);

    // 3x3 active-low: indices 9..15 do not exist and must not land anywhere
    wr2(9, 3); wr2(12, 3); wr2(15, 3); wr2(8, 2);
    bus2.swap_req = 1'b1; run(1); bus2.swap_req = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 9; i++) lit2[i] = 0;
    row2act = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (!row_out2[r] && !col_out2[c]) lit2[r*3 + c]++;
      if (!row_out2[2]) row2act++;
    end
    others = 0;
    for (int i = 0; i < 8; i++) others += lit2[i];
    chk("m2_pix8_lit", lit2[8], 2);
    chk("m2_oob_ignored", others, 0);
    chk("m2_row2_active", row2act, 3);
    enable2 = 1'b0;
    @(negedge clk);
    chk("m2_off_row", row_out2, 3'b111);
    chk("m2_off_col", col_out2, 3'b111);

    // 1: blank buffers, one swap, frame_start cadence
    pulse_swap();
    enable = 1'b1;
    clr();
    run(2*FP + 1);
    chk("t1_fs_count", fs_cnt, 3);
    chk("t1_fs_gap", fs_gap, 496);
    chk("t1_no_cols", anycol, 0);
    chk("t1_swap_once", done_cnt, 1);

    // 2/3: brightness levels and scan order
    wr(0, 15); wr(1, 8); wr(2, 0);
    pulse_swap();
    wait_done("t2_swap_timeout", 600);
    clr();
    run(FP);
    chk("t2_c0_lit", r0c[0], 60);
    chk("t2_c1_lit", r0c[1], 32);
    chk("t2_c2_lit", r0c[2], 0);
    for (int r = 0; r < 8; r++) chk($sformatf("t3_row%0d_active", r), row_cnt[r], 60);
    chk("t3_blank", blank_cnt, 16);
    chk("t3_onehot", bad_oh, 0);
    chk("t3_order", order_err, 0);

    // 4: swap requested mid-frame
    run(100);
    wr(8, 4);
    pulse_swap();
    chk("t4_pend_set", bus.swap_pend, 1);
    wait_done("t4_swap_timeout", 600);
    chk("t4_done_with_fs", frame_start, 1);
    chk("t4_pend_clear", bus.swap_pend, 0);
    clr();
    run(FP);
    chk("t4_no_extra_done", done_cnt, 0);

    // 5: write and re-request on the swap edge
    pulse_swap();
    run(FP - 2);
    bus.wr_en = 1'b1; bus.wr_addr = 6'd2; bus.wr_data = 4'd12; bus.swap_req = 1'b1;
    run(1);
    bus.wr_en = 1'b0; bus.swap_req = 1'b0;
    chk("t5_edge_done", bus.swap_done, 1);
    chk("t5_edge_pend", bus.swap_pend, 1);
    clr();
    run(FP);
    chk("t5_new_pix", r0c[2], 48);

    // 6: enable drop / re-enable / async reset
    n = 0;
    while (row_out == 0 && n < 200) begin run(1); n++; end
    chk("t6_reach_pwm", row_out != 0, 1);
    enable = 1'b0;
    run(1);
    chk("t6_off_row", row_out, 8'h00);
    chk("t6_off_col", col_out, 8'h00);
    run(5);
    enable = 1'b1;
    run(1);
    chk("t6_reen_fs", frame_start, 1);
    run(3);
    chk("t6_row0_first", row_out, 8'h01);
    run(200);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_row", row_out, 8'h00);
    chk("t6_rst_col", col_out, 8'h00);
    chk("t6_rst_pend", bus.swap_pend, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
